// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (pixel strobe, syncs, active flag, coordinates)
//
// Ports:
//   clk_in       board clock, the only clock in the block
//   i_rst        synchronous active-high reset
//   o_pix_stb    one-cycle pulse on each pixel advance
//   o_hs, o_vs   horizontal / vertical sync, asserted level SYNC_POL
//   o_active     current pixel lies in the visible area
//   o_x, o_y     current column / row, saturating at the last visible value in blanking
//   o_frame_end  one-cycle pulse on the final cycle of the last visible pixel
//
// Every output is registered from the next-state counter values, so the outputs
// always describe the counters of the same cycle.

module vga_timing_gen #(
  parameter int   PIX_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk_in,
  input  logic       i_rst,
  output logic       o_pix_stb,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_active,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_frame_end
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_MAX    = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_MAX    = 9'(V_ACTIVE - 1);

  logic [1:0] div_cnt, div_nxt;
  logic [9:0] h_cnt, h_nxt;
  logic [9:0] v_cnt, v_nxt;
  // High for the first cycle after reset; the divider holds at 0 for that
  // cycle so the first strobe lands PIX_DIV cycles after reset is released.
  logic       restart;

  logic       stb_nxt, hs_nxt, vs_nxt, active_nxt, fe_nxt;
  logic       h_vis, v_vis;
  logic [9:0] x_nxt;
  logic [8:0] y_nxt;

  // Counter advance; the registered strobe doubles as the advance enable.
  always_comb begin
    div_nxt = div_cnt;
    h_nxt   = h_cnt;
    v_nxt   = v_cnt;
    if (o_pix_stb) begin
      div_nxt = '0;
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        if (v_cnt == V_LAST) begin
          v_nxt = '0;
        end else begin
          v_nxt = v_cnt + 10'd1;
        end
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end else if (!restart) begin
      div_nxt = div_cnt + 2'd1;
    end
  end

  // Output decode of the next counter values.
  always_comb begin
    h_vis      = int'(h_nxt) < H_ACTIVE;
    v_vis      = int'(v_nxt) < V_ACTIVE;
    stb_nxt    = (div_nxt == DIV_LAST);
    active_nxt = h_vis && v_vis;
    x_nxt      = h_vis ? h_nxt : X_MAX;
    y_nxt      = v_vis ? v_nxt[8:0] : Y_MAX;
    hs_nxt     = (int'(h_nxt) >= HS_START && int'(h_nxt) < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_nxt     = (int'(v_nxt) >= VS_START && int'(v_nxt) < VS_END) ? SYNC_POL : ~SYNC_POL;
    fe_nxt     = stb_nxt && (h_nxt == X_MAX) && (int'(v_nxt) == V_ACTIVE - 1);
  end

  always_ff @(posedge clk_in) begin
    if (i_rst) begin
      restart     <= 1'b1;
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      o_pix_stb   <= 1'b0;
      o_hs        <= ~SYNC_POL;
      o_vs        <= ~SYNC_POL;
      o_active    <= 1'b1;
      o_x         <= '0;
      o_y         <= '0;
      o_frame_end <= 1'b0;
    end else begin
      restart     <= 1'b0;
      div_cnt     <= div_nxt;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      o_pix_stb   <= stb_nxt;
      o_hs        <= hs_nxt;
      o_vs        <= vs_nxt;
      o_active    <= active_nxt;
      o_x         <= x_nxt;
      o_y         <= y_nxt;
      o_frame_end <= fe_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
//
// Three instances share clock and reset: a shrunken raster with PIX_DIV=2,
// a shrunken raster with PIX_DIV=1 and positive sync, and the default 640x480.
// Expected outputs come from cycle arithmetic on the time since reset.

module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst = 1'b1;
  longint t   = 0;
  int     checks = 0;
  int     errors = 0;

  logic       a_stb, a_hs, a_vs, a_act, a_fe;
  logic [9:0] a_x;
  logic [8:0] a_y;
  logic       b_stb, b_hs, b_vs, b_act, b_fe;
  logic [9:0] b_x;
  logic [8:0] b_y;
  logic       c_stb, c_hs, c_vs, c_act, c_fe;
  logic [9:0] c_x;
  logic [8:0] c_y;

  logic [23:0] a_obs, b_obs, c_obs;
  assign a_obs = {a_stb, a_hs, a_vs, a_act, a_x, a_y, a_fe};
  assign b_obs = {b_stb, b_hs, b_vs, b_act, b_x, b_y, b_fe};
  assign c_obs = {c_stb, c_hs, c_vs, c_act, c_x, c_y, c_fe};

  vga_timing_gen #(
    .PIX_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) dut_a (
    .clk_in(clk), .i_rst(rst), .o_pix_stb(a_stb), .o_hs(a_hs), .o_vs(a_vs),
    .o_active(a_act), .o_x(a_x), .o_y(a_y), .o_frame_end(a_fe)
  );

  vga_timing_gen #(
    .PIX_DIV(1), .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(2),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_b (
    .clk_in(clk), .i_rst(rst), .o_pix_stb(b_stb), .o_hs(b_hs), .o_vs(b_vs),
    .o_active(b_act), .o_x(b_x), .o_y(b_y), .o_frame_end(b_fe)
  );

  vga_timing_gen dut_c (
    .clk_in(clk), .i_rst(rst), .o_pix_stb(c_stb), .o_hs(c_hs), .o_vs(c_vs),
    .o_active(c_act), .o_x(c_x), .o_y(c_y), .o_frame_end(c_fe)
  );

  // tt = cycles since the last reset edge; the first cycle after reset is a
  // restart cycle, after which pixel p spans cycles [1+p*pd, 1+(p+1)*pd).
  function automatic logic [23:0] ref_out(input int pd, input int ha, input int hf,
                                          input int hw, input int hb, input int va,
                                          input int vf, input int vw, input int vb,
                                          input logic sp, input longint tt);
    longint     s, p;
    int         ht, vt, h, v;
    logic       stb, act, hs, vs, fe;
    logic [9:0] x;
    logic [8:0] y;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    if (tt == 0) begin
      h = 0; v = 0; stb = 1'b0;
    end else begin
      s   = tt - 1;
      p   = s / pd;
      stb = ((s % pd) == pd - 1);
      h   = int'(p % ht);
      v   = int'((p / ht) % vt);
    end
    act = (h < ha) && (v < va);
    x   = (h < ha) ? 10'(h) : 10'(ha - 1);
    y   = (v < va) ? 9'(v) : 9'(va - 1);
    hs  = (h >= ha + hf && h < ha + hf + hw) ? sp : ~sp;
    vs  = (v >= va + vf && v < va + vf + vw) ? sp : ~sp;
    fe  = stb && (h == ha - 1) && (v == va - 1);
    return {stb, hs, vs, act, x, y, fe};
  endfunction

  function automatic longint at(input longint q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) t = 0; else t = t + 1;
    #1;
    chk("model_a", a_obs, ref_out(2, 16, 2, 3, 3, 8, 1, 2, 2, 1'b0, t));
    chk("model_b", b_obs, ref_out(1, 20, 4, 6, 2, 10, 2, 3, 1, 1'b1, t));
    chk("model_c", c_obs, ref_out(2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, t));
  endtask

  longint afe_q[$], bfe_q[$], chsf_q[$], chsr_q[$], cline_q[$], cact_q[$];
  longint avsf_q[$], avsr_q[$], bvsf_q[$], bvsr_q[$], bhsf_q[$], bhsr_q[$];
  longint a_first, b_first, c_rise;
  logic   p_chs, p_cact, p_avs, p_bvs, p_bhs;
  logic [9:0] p_cx;
  int     n_run;

  initial begin
    // Reset held three cycles.
    rst = 1'b1;
    repeat (3) step();
    chk("rst_x", a_x, 0);
    chk("rst_y", a_y, 0);
    chk("rst_active", a_act, 1);
    chk("rst_hs", a_hs, 1);
    chk("rst_vs", a_vs, 1);
    chk("rst_stb", a_stb, 0);
    chk("rst_fe", a_fe, 0);
    chk("rst_b_hs", b_hs, 0);
    chk("rst_b_stb", b_stb, 0);

    // First strobe after release.
    rst = 1'b0;
    a_first = -1;
    b_first = -1;
    for (int i = 0; i < 10 && a_first < 0; i++) begin
      step();
      if (b_stb && b_first < 0) b_first = t;
      if (a_stb && a_first < 0) a_first = t;
    end
    chk("first_stb_a", a_first, 2);
    chk("first_stb_b", b_first, 1);

    // Free-running line and frame timing.
    p_chs = c_hs; p_cact = c_act; p_cx = c_x;
    p_avs = a_vs; p_bvs = b_vs; p_bhs = b_hs;
    c_rise = -1;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (a_fe) begin
        afe_q.push_back(t);
        chk("fe_a_pos", {a_act, a_x, a_y}, {1'b1, 10'd15, 9'd7});
      end
      if (b_fe) bfe_q.push_back(t);
      if (p_chs && !c_hs) chsf_q.push_back(t);
      if (!p_chs && c_hs) chsr_q.push_back(t);
      if (p_cx != 10'd0 && c_x == 10'd0) cline_q.push_back(t);
      if (!p_cact && c_act) c_rise = t;
      if (p_cact && !c_act && c_rise >= 0) cact_q.push_back(t - c_rise);
      if (p_avs && !a_vs) avsf_q.push_back(t);
      if (!p_avs && a_vs) avsr_q.push_back(t);
      if (!p_bvs && b_vs) bvsr_q.push_back(t);
      if (p_bvs && !b_vs) bvsf_q.push_back(t);
      if (!p_bhs && b_hs) bhsr_q.push_back(t);
      if (p_bhs && !b_hs) bhsf_q.push_back(t);
      p_chs = c_hs; p_cact = c_act; p_cx = c_x;
      p_avs = a_vs; p_bvs = b_vs; p_bhs = b_hs;
    end

    chk("fe_a_count", afe_q.size(), 8);
    chk("fe_a_first", at(afe_q, 0), 368);
    for (int i = 1; i < afe_q.size(); i++) chk("fe_a_period", afe_q[i] - afe_q[i-1], 624);
    chk("fe_b_count", bfe_q.size(), 10);
    chk("fe_b_first", at(bfe_q, 0), 308);
    for (int i = 1; i < bfe_q.size(); i++) chk("fe_b_period", bfe_q[i] - bfe_q[i-1], 512);
    chk("hs_c_falls", chsf_q.size(), 3);
    chk("hs_c_line_period", at(chsf_q, 1) - at(chsf_q, 0), 1600);
    chk("hs_c_width", at(chsr_q, 0) - at(chsf_q, 0), 192);
    chk("hs_c_offset", at(chsf_q, 1) - at(cline_q, 0), 1312);
    chk("act_c_runs", cact_q.size(), 2);
    for (int i = 0; i < cact_q.size(); i++) chk("act_c_width", cact_q[i], 1280);
    chk("vs_a_start", at(avsf_q, 0), 433);
    chk("vs_a_width", at(avsr_q, 0) - at(avsf_q, 0), 96);
    chk("vs_b_start", at(bvsr_q, 0), 385);
    chk("vs_b_width", at(bvsf_q, 0) - at(bvsr_q, 0), 96);
    chk("hs_b_width", at(bhsf_q, 0) - at(bhsr_q, 0), 6);

    // Reset mid-frame on a strobe cycle at (10,5) of dut_a.
    n_run = 0;
    while (!(t > 0 && ((t - 1) % 624) == 261) && n_run < 2000) begin
      step();
      n_run++;
    end
    chk("mid_found", (t - 1) % 624, 261);
    chk("mid_x", a_x, 10);
    chk("mid_y", a_y, 5);
    chk("mid_stb", a_stb, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_x", a_x, 0);
    chk("mid_rst_y", a_y, 0);
    chk("mid_rst_stb", a_stb, 0);
    chk("mid_rst_active", a_act, 1);
    rst = 1'b0;
    a_first = -1;
    for (int i = 0; i < 10 && a_first < 0; i++) begin
      step();
      if (a_stb && a_first < 0) a_first = t;
    end
    chk("mid_first_stb", a_first, 2);

    // Random reset pulses at random positions.
    for (int r = 0; r < 12; r++) begin
      n_run = int'($urandom_range(900, 20));
      repeat (n_run) step();
      rst = 1'b1;
      n_run = int'($urandom_range(3, 1));
      repeat (n_run) step();
      rst = 1'b0;
    end
    repeat (700) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
